// File: rtl/smart_car_ctrl.sv
// smart_car_ctrl: two-motor smart car controller with line-follow, avoidance, cycle and remote modes.
// Latency: every output is registered, one clk from input change to output; no backpressure.
// Optional buzzer divider is built only when CAR_BEEP_EN is defined; otherwise beep is tied low.
module smart_car_ctrl #(
  parameter int PWM_W      = 8,
  parameter int DUTY       = 192,
  parameter int TICK_DIV   = 10000,
  parameter int BACK_TICKS = 300,
  parameter int TURN_TICKS = 400,
  parameter int FWD_TICKS  = 1000,
  parameter int BEEP_DIV   = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN_XUNJI,
  input  logic       EN_BIZHANG,
  input  logic       EN_BIZHANG1,
  input  logic       EN_CYCLE,
  input  logic       EN_YAOKONG,
  input  logic [3:0] DIN0,
  input  logic       DIN1,
  input  logic [3:0] DIN2,
  input  logic [4:1] key,
  output logic       zuo1,
  output logic       zuo2,
  output logic       you1,
  output logic       you2,
  output logic       en1,
  output logic       en2,
  output logic       beep,
  output logic       feng,
  output logic       led1,
  output logic [7:0] SEG,
  output logic       DIG
);

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_XUNJI = 3'd1,
    M_BIZ   = 3'd2,
    M_BIZ1  = 3'd3,
    M_CYCLE = 3'd4,
    M_YAO   = 3'd5
  } mode_t;

  typedef enum logic [2:0] {
    A_STOP,
    A_FWD,
    A_BACK,
    A_LEFT,
    A_RIGHT
  } act_t;

  // SQ_IDLE doubles as the forward phase of the cycle pattern.
  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_BACK,
    SQ_TURN,
    SQ_CTURN
  } seq_t;

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int SEQ_W  = 16;
  localparam int PW1    = PWM_W + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEQ_W-1:0]  BACK_LAST = SEQ_W'(BACK_TICKS - 1);
  localparam logic [SEQ_W-1:0]  TURN_LAST = SEQ_W'(TURN_TICKS - 1);
  localparam logic [SEQ_W-1:0]  FWD_LAST  = SEQ_W'(FWD_TICKS - 1);
  localparam logic [PWM_W:0]    DUTY_CMP  = PW1'(DUTY);

  mode_t             mode_q, mode_d;
  seq_t              seq_q, seq_eff;
  act_t              act_d, last_q, last_eff;
  logic [SEQ_W-1:0]  seq_cnt_q, cnt_eff;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic              turn_right_q;
  logic              mode_chg, tick, start_biz, start_biz1, in_seq, avoid_act, led_d;
  logic [1:0]        zuo_q, you_q;
  logic              en_q, feng_q, led_q, dig_q;
  logic [7:0]        seg_q, seg_d;

  // Mode select with fixed priority: remote wins over everything.
  always_comb begin
    mode_d = M_IDLE;
    if (EN_YAOKONG)       mode_d = M_YAO;
    else if (EN_XUNJI)    mode_d = M_XUNJI;
    else if (EN_BIZHANG)  mode_d = M_BIZ;
    else if (EN_BIZHANG1) mode_d = M_BIZ1;
    else if (EN_CYCLE)    mode_d = M_CYCLE;
  end

  // A mode change makes the sequence state look freshly cleared in the same cycle.
  assign mode_chg   = (mode_d != mode_q);
  assign seq_eff    = mode_chg ? SQ_IDLE : seq_q;
  assign cnt_eff    = mode_chg ? '0 : seq_cnt_q;
  assign last_eff   = mode_chg ? A_STOP : last_q;
  assign tick       = !mode_chg && (tick_cnt_q == TICK_LAST);
  assign start_biz  = (mode_d == M_BIZ)  && (seq_eff == SQ_IDLE) && DIN1;
  assign start_biz1 = (mode_d == M_BIZ1) && (seq_eff == SQ_IDLE) && DIN2[0];
  assign in_seq     = (seq_eff == SQ_BACK) || (seq_eff == SQ_TURN);
  assign avoid_act  = start_biz || start_biz1 || in_seq;
  assign led_d      = avoid_act || ((mode_d == M_XUNJI) && (DIN0 == 4'b0000));

  // Per-mode action decode from sensors, keys and sequence phase.
  always_comb begin
    act_d = A_STOP;
    case (mode_d)
      M_XUNJI: begin
        case (DIN0)
          4'b0110, 4'b1111:                   act_d = A_FWD;
          4'b1100, 4'b1000, 4'b1110, 4'b0100: act_d = A_LEFT;
          4'b0011, 4'b0001, 4'b0111, 4'b0010: act_d = A_RIGHT;
          4'b0000:                            act_d = last_eff;
          default:                            act_d = A_FWD;
        endcase
      end
      M_BIZ, M_BIZ1: begin
        if ((seq_eff == SQ_BACK) || start_biz || start_biz1) act_d = A_BACK;
        else if (seq_eff == SQ_TURN) act_d = turn_right_q ? A_RIGHT : A_LEFT;
        else if (mode_d == M_BIZ)    act_d = A_FWD;
        else if (DIN2[1])            act_d = A_RIGHT;
        else if (DIN2[2])            act_d = A_LEFT;
        else if (DIN2[3])            act_d = A_FWD;  // rear alone: drive away forward
        else                         act_d = A_FWD;
      end
      M_CYCLE: act_d = (seq_eff == SQ_CTURN) ? A_RIGHT : A_FWD;
      M_YAO: begin
        case (key)
          4'b0001: act_d = A_FWD;
          4'b0010: act_d = A_BACK;
          4'b0100: act_d = A_LEFT;
          4'b1000: act_d = A_RIGHT;
          default: act_d = A_STOP;
        endcase
      end
      default: act_d = A_STOP;
    endcase
  end

  // Mode-code to common-anode 7-segment pattern.
  always_comb begin
    case (mode_d)
      M_IDLE:  seg_d = 8'hC0;
      M_XUNJI: seg_d = 8'hF9;
      M_BIZ:   seg_d = 8'hA4;
      M_BIZ1:  seg_d = 8'hB0;
      M_CYCLE: seg_d = 8'h99;
      M_YAO:   seg_d = 8'h92;
      default: seg_d = 8'hFF;
    endcase
  end

  // Tick prescaler and free-running PWM counter; the tick restarts on mode change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      if (mode_chg || (tick_cnt_q == TICK_LAST)) tick_cnt_q <= '0;
      else                                       tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Sequence FSM: avoidance back/turn phases and the forward/turn cycle, timed in ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= M_IDLE;
      seq_q        <= SQ_IDLE;
      seq_cnt_q    <= '0;
      turn_right_q <= 1'b1;
      last_q       <= A_STOP;
    end else begin
      mode_q    <= mode_d;
      last_q    <= (act_d != A_STOP) ? act_d : last_eff;
      seq_q     <= seq_eff;
      seq_cnt_q <= cnt_eff;
      case (seq_eff)
        SQ_IDLE: begin
          if (start_biz) begin
            seq_q        <= SQ_BACK;
            seq_cnt_q    <= '0;
            turn_right_q <= 1'b1;
          end else if (start_biz1) begin
            seq_q        <= SQ_BACK;
            seq_cnt_q    <= '0;
            turn_right_q <= DIN2[1];
          end else if ((mode_d == M_CYCLE) && tick) begin
            if (cnt_eff == FWD_LAST) begin
              seq_q     <= SQ_CTURN;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= cnt_eff + SEQ_W'(1);
            end
          end
        end
        SQ_BACK: begin
          if (tick) begin
            if (cnt_eff == BACK_LAST) begin
              seq_q     <= SQ_TURN;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= cnt_eff + SEQ_W'(1);
            end
          end
        end
        SQ_TURN, SQ_CTURN: begin
          if (tick) begin
            if (cnt_eff == TURN_LAST) begin
              seq_q     <= SQ_IDLE;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= cnt_eff + SEQ_W'(1);
            end
          end
        end
        default: seq_q <= SQ_IDLE;
      endcase
    end
  end

  // Registered motor, PWM, indicator and display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zuo_q  <= 2'b00;
      you_q  <= 2'b00;
      en_q   <= 1'b0;
      feng_q <= 1'b0;
      led_q  <= 1'b0;
      seg_q  <= 8'hFF;
      dig_q  <= 1'b1;
    end else begin
      case (act_d)
        A_FWD:   begin zuo_q <= 2'b10; you_q <= 2'b10; end
        A_BACK:  begin zuo_q <= 2'b01; you_q <= 2'b01; end
        A_LEFT:  begin zuo_q <= 2'b01; you_q <= 2'b10; end
        A_RIGHT: begin zuo_q <= 2'b10; you_q <= 2'b01; end
        default: begin zuo_q <= 2'b00; you_q <= 2'b00; end
      endcase
      en_q   <= (act_d != A_STOP) && ({1'b0, pwm_cnt_q} < DUTY_CMP);
      feng_q <= (mode_d != M_IDLE);
      led_q  <= led_d;
      seg_q  <= seg_d;
      dig_q  <= 1'b0;
    end
  end

`ifdef CAR_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_DIV + 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_DIV - 1);
  logic [BEEP_W-1:0] beep_div_q;
  logic              beep_q, beep_en;
  assign beep_en = avoid_act || ((mode_d == M_YAO) && key[2]);

  // Buzzer square wave, half-period BEEP_DIV cycles, silent and re-phased when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !beep_en) begin
      beep_div_q <= '0;
      beep_q     <= 1'b0;
    end else if (beep_div_q == BEEP_LAST) begin
      beep_div_q <= '0;
      beep_q     <= ~beep_q;
    end else begin
      beep_div_q <= beep_div_q + BEEP_W'(1);
    end
  end
  assign beep = beep_q;
`else
  // BEEP_DIV stays in the parameter list so both builds share one instantiation.
  assign beep = 1'b0 && (BEEP_DIV > 0);
`endif

  assign {zuo1, zuo2} = zuo_q;
  assign {you1, you2} = you_q;
  assign en1  = en_q;
  assign en2  = en_q;
  assign feng = feng_q;
  assign led1 = led_q;
  assign SEG  = seg_q;
  assign DIG  = dig_q;

endmodule

// File: tb/tb_smart_car_ctrl.sv
// Directed testbench for smart_car_ctrl with a queue scoreboard of expected outputs.
module tb_smart_car_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       EN_XUNJI, EN_BIZHANG, EN_BIZHANG1, EN_CYCLE, EN_YAOKONG;
  logic [3:0] DIN0;
  logic       DIN1;
  logic [3:0] DIN2;
  logic [4:1] key;
  logic       zuo1, zuo2, you1, you2, en1, en2, beep, feng, led1;
  logic [7:0] SEG;
  logic       DIG;

  always #5 clk = ~clk;

  smart_car_ctrl #(
    .PWM_W(8), .DUTY(128), .TICK_DIV(10), .BACK_TICKS(3),
    .TURN_TICKS(3), .FWD_TICKS(5), .BEEP_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .EN_XUNJI(EN_XUNJI), .EN_BIZHANG(EN_BIZHANG), .EN_BIZHANG1(EN_BIZHANG1),
    .EN_CYCLE(EN_CYCLE), .EN_YAOKONG(EN_YAOKONG),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .key(key),
    .zuo1(zuo1), .zuo2(zuo2), .you1(you1), .you2(you2),
    .en1(en1), .en2(en2), .beep(beep), .feng(feng), .led1(led1),
    .SEG(SEG), .DIG(DIG)
  );

  localparam logic [1:0] MF = 2'b10;
  localparam logic [1:0] MR = 2'b01;
  localparam logic [1:0] MS = 2'b00;

  typedef struct {
    string      tag;
    logic [1:0] zuo;
    logic [1:0] you;
    logic [7:0] seg;
    logic       dig;
    logic       feng;
    logic       led1;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  logic beep_prev = 1'b0;
  int   beep_rise[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
    if (beep && !beep_prev) beep_rise.push_back(cyc_no);
    beep_prev = beep;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] z, input logic [1:0] y,
                            input logic [7:0] seg, input logic dig, input logic f,
                            input logic l);
    exp_t e;
    e.tag = tag; e.zuo = z; e.you = y; e.seg = seg; e.dig = dig; e.feng = f; e.led1 = l;
    sb_q.push_back(e);
  endtask

  // Advance one clock, then compare every pending expectation against the outputs.
  task automatic step();
    exp_t e;
    cyc();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".zuo"},  {30'd0, zuo1, zuo2}, {30'd0, e.zuo});
      chk({e.tag, ".you"},  {30'd0, you1, you2}, {30'd0, e.you});
      chk({e.tag, ".seg"},  {24'd0, SEG}, {24'd0, e.seg});
      chk({e.tag, ".dig"},  {31'd0, DIG}, {31'd0, e.dig});
      chk({e.tag, ".feng"}, {31'd0, feng}, {31'd0, e.feng});
      chk({e.tag, ".led1"}, {31'd0, led1}, {31'd0, e.led1});
      if (e.zuo == MS && e.you == MS) chk({e.tag, ".en"}, {30'd0, en1, en2}, 32'd0);
    end
  endtask

  // Count consecutive cycles showing the given motor pattern, checking led1 on each.
  task automatic run_len(input logic [1:0] z, input logic [1:0] y, input logic led_exp,
                         input int bound, output int n, output int bad);
    n = 0;
    bad = 0;
    while (n < bound && {zuo1, zuo2} == z && {you1, you2} == y) begin
      if (led1 !== led_exp) bad++;
      n++;
      cyc();
    end
  endtask

  int n, bad, c1, c2;

  initial begin
    rst_n = 1'b0;
    EN_XUNJI = 0; EN_BIZHANG = 0; EN_BIZHANG1 = 0; EN_CYCLE = 0; EN_YAOKONG = 0;
    DIN0 = 4'b0000; DIN1 = 1'b0; DIN2 = 4'b0000; key = 4'b0000;

    // Reset held for two edges.
    cyc();
    expect_out("reset", MS, MS, 8'hFF, 1'b1, 1'b0, 1'b0);
    step();
    chk("reset.beep", {31'd0, beep}, 32'd0);

    rst_n = 1'b1;
    expect_out("idle", MS, MS, 8'hC0, 1'b0, 1'b0, 1'b0);
    step();

    // Line following.
    EN_XUNJI = 1; DIN0 = 4'b0110;
    expect_out("xunji.fwd", MF, MF, 8'hF9, 1'b0, 1'b1, 1'b0);
    step();
    DIN0 = 4'b1000;
    expect_out("xunji.left", MR, MF, 8'hF9, 1'b0, 1'b1, 1'b0);
    step();
    DIN0 = 4'b0000;
    expect_out("xunji.hold1", MR, MF, 8'hF9, 1'b0, 1'b1, 1'b1);
    step();
    expect_out("xunji.hold2", MR, MF, 8'hF9, 1'b0, 1'b1, 1'b1);
    step();
    DIN0 = 4'b0011;
    expect_out("xunji.right", MF, MR, 8'hF9, 1'b0, 1'b1, 1'b0);
    step();
    DIN0 = 4'b1010;
    expect_out("xunji.other", MF, MF, 8'hF9, 1'b0, 1'b1, 1'b0);
    step();

    // Remote overrides line following.
    EN_YAOKONG = 1; key = 4'b0001;
    expect_out("yk.fwd", MF, MF, 8'h92, 1'b0, 1'b1, 1'b0);
    step();
    key = 4'b0100;
    expect_out("yk.left", MR, MF, 8'h92, 1'b0, 1'b1, 1'b0);
    step();
    key = 4'b0011;
    expect_out("yk.multi", MS, MS, 8'h92, 1'b0, 1'b1, 1'b0);
    step();
    key = 4'b0010;
    expect_out("yk.back", MR, MR, 8'h92, 1'b0, 1'b1, 1'b0);
    step();
    key = 4'b0000;
    expect_out("yk.none", MS, MS, 8'h92, 1'b0, 1'b1, 1'b0);
    step();

    // Front avoidance sequence.
    EN_YAOKONG = 0; EN_XUNJI = 0; EN_BIZHANG = 1;
    expect_out("biz.fwd", MF, MF, 8'hA4, 1'b0, 1'b1, 1'b0);
    step();
    DIN1 = 1'b1;
    cyc();
    DIN1 = 1'b0;
    beep_rise.delete();
    run_len(MR, MR, 1'b1, 100, n, bad);
    chk("biz.back_len_in_20_40", {31'd0, (n >= 20 && n <= 40)}, 32'd1);
    chk("biz.back_led", bad, 0);
`ifdef CAR_BEEP_EN
    chk("biz.beep_rises", {31'd0, (beep_rise.size() >= 2)}, 32'd1);
    if (beep_rise.size() >= 2) chk("biz.beep_period", beep_rise[1] - beep_rise[0], 8);
`else
    chk("biz.beep_rises", beep_rise.size(), 0);
`endif
    run_len(MF, MR, 1'b1, 100, n, bad);
    chk("biz.turn_len_in_20_40", {31'd0, (n >= 20 && n <= 40)}, 32'd1);
    chk("biz.turn_led", bad, 0);
    chk("biz.after_motor", {28'd0, zuo1, zuo2, you1, you2}, {28'd0, MF, MF});
    chk("biz.after_led", {31'd0, led1}, 32'd0);

    // Four-sensor avoidance.
    EN_BIZHANG = 0; EN_BIZHANG1 = 1; DIN2 = 4'b0010;
    expect_out("biz1.left_obs", MF, MR, 8'hB0, 1'b0, 1'b1, 1'b0);
    step();
    DIN2 = 4'b0100;
    expect_out("biz1.right_obs", MR, MF, 8'hB0, 1'b0, 1'b1, 1'b0);
    step();
    DIN2 = 4'b1000;
    expect_out("biz1.rear_obs", MF, MF, 8'hB0, 1'b0, 1'b1, 1'b0);
    step();
    DIN2 = 4'b0000;
    expect_out("biz1.clear", MF, MF, 8'hB0, 1'b0, 1'b1, 1'b0);
    step();
    DIN2 = 4'b0001;
    cyc();
    DIN2 = 4'b0000;
    run_len(MR, MR, 1'b1, 100, n, bad);
    chk("biz1.back_len_in_20_40", {31'd0, (n >= 20 && n <= 40)}, 32'd1);
    run_len(MR, MF, 1'b1, 100, n, bad);
    chk("biz1.left_turn_len_in_20_40", {31'd0, (n >= 20 && n <= 40)}, 32'd1);
    chk("biz1.turn_led", bad, 0);
    chk("biz1.after_motor", {28'd0, zuo1, zuo2, you1, you2}, {28'd0, MF, MF});

    // Timed cycle pattern, aborted mid-turn.
    EN_BIZHANG1 = 0; EN_CYCLE = 1;
    cyc();
    chk("cyc.seg", {24'd0, SEG}, 32'h99);
    run_len(MF, MF, 1'b0, 100, n, bad);
    chk("cyc.fwd1_len_in_40_60", {31'd0, (n >= 40 && n <= 60)}, 32'd1);
    run_len(MF, MR, 1'b0, 100, n, bad);
    chk("cyc.turn1_len_in_20_40", {31'd0, (n >= 20 && n <= 40)}, 32'd1);
    run_len(MF, MF, 1'b0, 100, n, bad);
    chk("cyc.fwd2_len_in_40_60", {31'd0, (n >= 40 && n <= 60)}, 32'd1);
    chk("cyc.led", bad, 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("cyc.mid_turn", {28'd0, zuo1, zuo2, you1, you2}, {28'd0, MF, MR});
    EN_CYCLE = 0;
    expect_out("cyc.abort", MS, MS, 8'hC0, 1'b0, 1'b0, 1'b0);
    step();

    // PWM duty on a steady forward drive.
    EN_XUNJI = 1; DIN0 = 4'b0110;
    expect_out("pwm.fwd", MF, MF, 8'hF9, 1'b0, 1'b1, 1'b0);
    step();
    c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      if (en1) c1++;
      if (en2) c2++;
      cyc();
    end
    chk("pwm.en1_high", c1, 128);
    chk("pwm.en2_high", c2, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
